// File: rtl/saver_core.sv
// ---------------------------------------------------------------------------
// saver_core
//
// Slot-allocation controller for the smart-lock code store. A start request
// scans the four slots of the external code memory in order (0..3), looking at
// each slot's occupied flag. The first free slot is reported on save_addr
// with a one-cycle save_start/finish pulse. If all four slots are occupied,
// the block pulses finish and raises error.
//
// Optional feature (macro SAVER_OVERWRITE_EN):
//   When defined, a full table does not raise error. Instead a victim slot is
//   taken from an internal 2-bit round-robin pointer. save_addr is loaded with
//   the pointer, save_start/finish are pulsed, and the pointer increments.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous active-low reset
//   start       in   1   scan request, only sampled while idle
//   data_in     in  17   slot word at read_addr (bit 16 = occupied flag)
//   read_addr   out  2   slot currently examined (registered)
//   save_addr   out  2   selected free slot (registered, held between scans)
//   save_start  out  1   one-cycle pulse: write new code into save_addr
//   finish      out  1   one-cycle pulse: scan ended
//   error       out  1   level: last scan found no free slot
// ---------------------------------------------------------------------------
module saver_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [16:0] data_in,
    output logic [1:0]  read_addr,
    output logic [1:0]  save_addr,
    output logic        save_start,
    output logic        finish,
    output logic        error
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  read_addr_nxt_s;
    logic [1:0]  save_addr_nxt_s;
    logic        save_start_nxt_s;
    logic        finish_nxt_s;
    logic        error_nxt_s;
    logic        scan_active_s;
    logic        occupied_s;

    // The stored code bits are irrelevant to slot allocation.
    logic        unused_code_s;
    assign unused_code_s = ^data_in[15:0];
    assign occupied_s    = data_in[16];

`ifdef SAVER_OVERWRITE_EN
    logic [1:0]  victim_r;
    logic [1:0]  victim_nxt_s;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            read_addr  <= 2'd0;
            save_addr  <= 2'd0;
            save_start <= 1'b0;
            finish     <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            read_addr  <= read_addr_nxt_s;
            save_addr  <= save_addr_nxt_s;
            save_start <= save_start_nxt_s;
            finish     <= finish_nxt_s;
            error      <= error_nxt_s;
        end
    end

`ifdef SAVER_OVERWRITE_EN
    // Round-robin victim pointer for full-table overwrites.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            victim_r <= 2'd0;
        end else begin
            victim_r <= victim_nxt_s;
        end
    end
`endif

    // Slot examination is active in SCAN, or in IDLE on the accepting cycle.
    always_comb begin
        scan_active_s = 1'b0;
        case (state_r)
            ST_IDLE: scan_active_s = start;
            ST_SCAN: scan_active_s = 1'b1;
            default: scan_active_s = 1'b0;
        endcase
    end

    // Next-state and next-output decision for the slot at read_addr.
    // read_addr is always 0 in IDLE, so the accepting cycle examines slot 0.
    always_comb begin
        state_nxt_s      = state_r;
        read_addr_nxt_s  = read_addr;
        save_addr_nxt_s  = save_addr;
        save_start_nxt_s = 1'b0;
        finish_nxt_s     = 1'b0;
        error_nxt_s      = error;
`ifdef SAVER_OVERWRITE_EN
        victim_nxt_s     = victim_r;
`endif
        if (scan_active_s) begin
            if (!occupied_s) begin
                save_addr_nxt_s  = read_addr;
                save_start_nxt_s = 1'b1;
                finish_nxt_s     = 1'b1;
                error_nxt_s      = 1'b0;
                state_nxt_s      = ST_IDLE;
                read_addr_nxt_s  = 2'd0;
            end else if (read_addr != 2'd3) begin
                // Error from a previous scan is cleared as soon as a scan runs.
                error_nxt_s      = 1'b0;
                state_nxt_s      = ST_SCAN;
                read_addr_nxt_s  = read_addr + 2'd1;
            end else begin
                finish_nxt_s     = 1'b1;
                state_nxt_s      = ST_IDLE;
                read_addr_nxt_s  = 2'd0;
`ifdef SAVER_OVERWRITE_EN
                save_addr_nxt_s  = victim_r;
                save_start_nxt_s = 1'b1;
                error_nxt_s      = 1'b0;
                victim_nxt_s     = victim_r + 2'd1;
`else
                error_nxt_s      = 1'b1;
`endif
            end
        end else begin
            // Idle without a request (or an illegal state): park in IDLE.
            state_nxt_s     = ST_IDLE;
            read_addr_nxt_s = 2'd0;
        end
    end

endmodule

// File: tb/tb_saver_core.sv
// ---------------------------------------------------------------------------
// tb_saver_core
//
// Directed bench for saver_core. Each scan pushes its expected result into a
// scoreboard queue; a monitor pops and compares whenever finish is seen.
// The code memory is a small array read asynchronously at read_addr.
// Define SAVER_OVERWRITE_EN for both bench and RTL to check the overwrite mode.
// ---------------------------------------------------------------------------
module tb_saver_core;

`ifdef SAVER_OVERWRITE_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] addr;
        logic       ss;
        logic       err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [16:0] data_in;
    logic [1:0]  read_addr;
    logic [1:0]  save_addr;
    logic        save_start;
    logic        finish;
    logic        error;

    logic [16:0] mem [4];
    exp_t        sb [$];
    exp_t        mon_e;
    int          vectors;
    int          miscompares;

    // Model state
    logic [1:0]  exp_save;
    logic [1:0]  ptr;
    logic        err_lvl;

    saver_core dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
        .read_addr  (read_addr),
        .save_addr  (save_addr),
        .save_start (save_start),
        .finish     (finish),
        .error      (error)
    );

    assign data_in = mem[read_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every finish pulse against the scoreboard head.
    always @(negedge clk) begin
        if (reset === 1'b1 && finish === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_finish: got finish=1 expected no result at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("save_addr",  {30'd0, save_addr}, {30'd0, mon_e.addr});
                chk("save_start", {31'd0, save_start}, {31'd0, mon_e.ss});
                chk("error",      {31'd0, error},      {31'd0, mon_e.err});
            end
        end
    end

    task automatic exp_free(input logic [1:0] k, output exp_t e);
        e.addr   = k;
        e.ss     = 1'b1;
        e.err    = 1'b0;
        exp_save = k;
        err_lvl  = 1'b0;
    endtask

    task automatic exp_full(output exp_t e);
        if (OVR) begin
            e.addr   = ptr;
            e.ss     = 1'b1;
            e.err    = 1'b0;
            exp_save = ptr;
            ptr      = ptr + 2'd1;
            err_lvl  = 1'b0;
        end else begin
            e.addr   = exp_save;
            e.ss     = 1'b0;
            e.err    = 1'b1;
            err_lvl  = 1'b1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_read_addr"},  {30'd0, read_addr},  32'd0);
        chk({tag, "_save_start"}, {31'd0, save_start}, 32'd0);
        chk({tag, "_finish"},     {31'd0, finish},     32'd0);
        chk({tag, "_error"},      {31'd0, error},      {31'd0, err_lvl});
        chk({tag, "_save_addr"},  {30'd0, save_addr},  {30'd0, exp_save});
    endtask

    // Run one scan; inputs change 1 time unit after the rising edge.
    task automatic run_scan(input logic [16:0] s0, input logic [16:0] s1,
                            input logic [16:0] s2, input logic [16:0] s3,
                            input exp_t e, input int lat, input bit repulse);
        int n;
        mem[0] = s0; mem[1] = s1; mem[2] = s2; mem[3] = s3;
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1 start = repulse;
        n = 0;
        while (n < 20 && sb.size() != 0) begin
            @(posedge clk);
            n++;
            #1 start = 1'b0;
        end
        chk("latency", n, lat);
        if (sb.size() != 0) sb.delete();
        // Cycle after the result: pulses must be gone.
        @(negedge clk);
        check_idle_outputs("post");
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        vectors     = 0;
        miscompares = 0;
        exp_save    = 2'd0;
        ptr         = 2'd0;
        err_lvl     = 1'b0;
        start       = 1'b0;
        reset       = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 17'h1FFFF;

        // Reset held low
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("idle");
        @(posedge clk);
        #1;

        // Slot 0 free
        exp_free(2'd0, e);
        run_scan(17'h0FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, e, 1, 1'b0);

        // Slot 1 free
        exp_free(2'd1, e);
        run_scan(17'h1FFFF, 17'h0FFFF, 17'h1FFFF, 17'h1FFFF, e, 2, 1'b0);

        // Table full
        exp_full(e);
        run_scan(17'h1FFFF, 17'h1AAAA, 17'h15555, 17'h1FFFF, e, 4, 1'b0);
        // error level holds while idle
        repeat (3) begin
            @(negedge clk);
            chk("error_hold", {31'd0, error}, {31'd0, err_lvl});
            chk("finish_hold", {31'd0, finish}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Next start clears error, slot 3 free
        exp_free(2'd3, e);
        run_scan(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h00000, e, 4, 1'b0);

        // start re-pulsed during the scan is ignored
        exp_free(2'd2, e);
        run_scan(17'h1FFFF, 17'h1FFFF, 17'h0AAAA, 17'h1FFFF, e, 3, 1'b1);

        // Reset mid-scan (cycle 2)
        for (int i = 0; i < 4; i++) mem[i] = 17'h1FFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        exp_save = 2'd0;
        ptr      = 2'd0;
        err_lvl  = 1'b0;
        check_idle_outputs("midreset");
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(negedge clk);
        check_idle_outputs("after_reset");
        chk("sb_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;

        // Two full-table scans
        exp_full(e);
        run_scan(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, e, 4, 1'b0);
        exp_full(e);
        run_scan(17'h10000, 17'h1FFFF, 17'h11234, 17'h1FFFF, e, 4, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
